cfu_exp_series: RTL
===================

// Module: cfu_exp_series
// PURPOSE
// CFU-side fixed-point exp(x) unit, successor to the single-mode Taylor-series CFU.
// Generalises data width, input fraction bits and series order.
// Adds a range-reduced mode, x = r - k*ln2, exp(x) = exp(r) >> k, so large negative inputs (softmax logits) stay accurate.
// Adds output saturation and a true valid/ready response handshake.
// Sits directly on the CPU CFU bus: cmd in, rsp out.
// PARAMETERS
// DATA_W   32  operand/result width; input is Q(DATA_W-1-FRAC_IN).FRAC_IN, output is Q0.(DATA_W-1)
// FRAC_IN  27  fractional bits of inputs_0 (range 16..DATA_W-2)
// N_TERMS  6   highest series power (2..12); 1/i constants come from an internal ROM, i=1..N_TERMS
// PORTS
// clk                    in   1       single clock, rising edge
// reset_n                in   1       asynchronous active-low reset
// cmd_valid              in   1       command request
// cmd_ready              out  1       high only in IDLE
// cmd_payload_function_id in  10      [2:0] mode: 0=direct series, 1=range-reduced; others unsupported
// cmd_payload_inputs_0   in   DATA_W  x, signed fixed-point
// cmd_payload_inputs_1   in   DATA_W  unused, ignored
// rsp_valid              out  1       result valid, held until rsp_ready
// rsp_ready              in   1       response accept
// rsp_payload_outputs_0  out  DATA_W  exp(x) in Q0.(DATA_W-1), signed-positive
// BEHAVIOUR
// - Reset (async, reset_n=0): state=IDLE, rsp_valid=0, rsp_payload_outputs_0=0, cmd_ready=1.
//   All datapath registers are cleared. Asserting reset mid-operation aborts the op; no response is produced.
// - Accept: cmd is accepted on a rising edge with cmd_valid & cmd_ready; x and mode are latched.
// - FSM: IDLE -> [RED_K -> RED_R] (mode 1 only) -> INIT -> {MUL -> SCALE -> ACC} x N_TERMS -> DONE -> RESP -> IDLE.
//   Unsupported mode: IDLE -> RESP with payload 0.
// - RED_K: k = floor(-x * INV_LN2), computed with a DATA_W x DATA_W multiply and truncated to an integer.
//   If x >= 0, go straight to RESP with payload {0, all ones}.
// - RED_R: r = x + k*LN2, giving r in (-ln2, 0]. LN2 and INV_LN2 are localparams rounded to FRAC_IN bits.
// - INIT: acc = 1.0, term = 1.0, i = 1. The series operand is r in mode 1 and x in mode 0.
// - MUL: p = term * operand, a 2*DATA_W product.
// - SCALE: term = (p >>> FRAC_IN) * RECIP[i], again rescaled by >>> FRAC_IN.
// - ACC: acc += term; i++.
// - All products are full signed 2*DATA_W and rescaled by arithmetic shift (truncate toward -inf).
//   No intermediate saturation.
// - DONE: conversion to output format.
//   - y = acc << (DATA_W-1-FRAC_IN), saturating.
//   - acc >= 1.0 -> {0, all ones}.
//   - acc < 0 (mode 0 divergence) -> 0.
//   - Mode 1: y >>= k; if k >= DATA_W-1 -> 0.
// - RESP: rsp_valid=1 with payload stable. On rsp_valid & rsp_ready -> IDLE: rsp_valid=0 and cmd_ready=1 on the next cycle.
// - Latency from the accepting edge to rsp_valid rising:
//   - mode 0: 3*N_TERMS+2 clocks (20 at default);
//   - mode 1: 3*N_TERMS+4 clocks;
//   - unsupported mode or x >= 0 in mode 1: 1 clock (from RED_K: 2).
// - One command in flight; cmd_ready is low from accept until the response handshake.
//   cmd_valid held during busy is ignored.
// - Simultaneous rsp_ready and a new cmd_valid in RESP: only the response completes.
//   The command is accepted no earlier than the following cycle.
// TESTING
// 1. mode0, x=0x00000000 -> payload 0x7FFFFFFF (1.0 saturated), latency 20.
// 2. mode0, x=0xF8000000 (-1.0), N_TERMS=6 -> 0x2F1C71C7 +/-64 LSB (series sum 53/144).
// 3. mode1, x=0xC0000000 (-8.0) -> k=11, payload 0x000AFE11 +/-0.1% relative, latency 22.
// 4. mode1, x=0x80000000 (-16.0) -> k=23, payload 0x000000F1 +/-2; mode1 x=0x08000000 -> 0x7FFFFFFF.
// 5. rsp_ready held low 5 cycles after rsp_valid -> payload and rsp_valid stable; cmd_ready=0; a second cmd is not taken.
// 6. reset_n pulsed low mid-series -> rsp_valid=0 and cmd_ready=1 immediately; the next cmd (x=-1.0, mode0) returns a correct result.

Source files
------------

// File: rtl/cfu_exp_series_if.sv
`default_nettype none
// ============================================================================
// Module   : cfu_exp_series_if
// Brief    : CFU command/response bus carrying one exp(x) request and result
// Revision : 1.0
// ============================================================================
interface cfu_exp_series_if #(
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_payload_function_id;
    logic [DATA_W-1:0] cmd_payload_inputs_0;
    logic [DATA_W-1:0] cmd_payload_inputs_1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_payload_function_id,
        output cmd_payload_inputs_0,
        output cmd_payload_inputs_1,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_payload_function_id,
        input  cmd_payload_inputs_0,
        input  cmd_payload_inputs_1,
        output rsp_valid,
        input  rsp_ready,
        output rsp_payload_outputs_0
    );
endinterface
`default_nettype wire

// File: rtl/cfu_exp_series.sv
`default_nettype none
// ============================================================================
// Module   : cfu_exp_series
// Brief    : CFU fixed-point exp(x) via Taylor series, with optional ln2 range reduction
// Revision : 1.0
// ============================================================================
module cfu_exp_series #(
    parameter int DATA_W  = 32,
    parameter int FRAC_IN = 27,
    parameter int N_TERMS = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    cfu_exp_series_if.slave bus
);
    localparam int c_pw        = 2 * DATA_W;
    localparam int c_i_w       = $clog2(N_TERMS + 1);
    localparam int c_out_shift = DATA_W - 1 - FRAC_IN;

    localparam logic [63:0] c_ln2_q64   = 64'hB17217F7D1CF79AB;
    localparam logic [63:0] c_log2e_q60 = 64'h171547652B82FE17;
    localparam logic [63:0] c_one64     = 64'd1 << FRAC_IN;

    // Constants rounded to nearest at FRAC_IN fractional bits
    localparam logic signed [DATA_W-1:0] c_one     = DATA_W'(c_one64);
    localparam logic signed [DATA_W-1:0] c_ln2     = DATA_W'((c_ln2_q64 >> (64 - FRAC_IN))
                                                      + ((c_ln2_q64 >> (63 - FRAC_IN)) & 64'd1));
    localparam logic signed [DATA_W-1:0] c_inv_ln2 = DATA_W'((c_log2e_q60 >> (60 - FRAC_IN))
                                                      + ((c_log2e_q60 >> (59 - FRAC_IN)) & 64'd1));
    localparam logic [DATA_W-1:0] c_sat   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_k_max = DATA_W'(DATA_W - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RED_K = 4'd1,
        S_RED_R = 4'd2,
        S_INIT  = 4'd3,
        S_MUL   = 4'd4,
        S_SCALE = 4'd5,
        S_ACC   = 4'd6,
        S_DONE  = 4'd7,
        S_RESP  = 4'd8
    } state_t;

    state_t                    r_state;
    logic                      r_cmd_ready;
    logic                      r_rsp_valid;
    logic [DATA_W-1:0]         r_y;
    logic [2:0]                r_mode;
    logic signed [DATA_W-1:0]  r_x;
    logic signed [DATA_W-1:0]  r_operand;
    logic signed [DATA_W-1:0]  r_term;
    logic signed [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]         r_k;
    logic signed [c_pw-1:0]    r_prod;
    logic [c_i_w-1:0]          r_i;
    logic                      r_bypass;
    logic                      r_bypass_sat;

    function automatic logic signed [c_pw-1:0] sext(input logic [DATA_W-1:0] v);
        return {{DATA_W{v[DATA_W-1]}}, v};
    endfunction

    // 1/i ROM; entry 0 and entries above N_TERMS are never selected
    logic signed [DATA_W-1:0] w_recip [0:(1<<c_i_w)-1];
    for (genvar g = 0; g < (1 << c_i_w); g++) begin : g_recip
        localparam logic [63:0] c_div = 64'((g == 0) ? 1 : g);
        assign w_recip[g] = DATA_W'((c_one64 + (c_div >> 1)) / c_div);
    end

    logic signed [c_pw-1:0]   w_neg_x;
    logic signed [c_pw-1:0]   w_k_prod;
    logic signed [c_pw-1:0]   w_kln2_prod;
    logic signed [c_pw-1:0]   w_mul;
    logic signed [c_pw-1:0]   w_scale_prod;
    logic signed [DATA_W-1:0] w_p_scaled;
    logic signed [DATA_W-1:0] w_term_next;
    logic signed [DATA_W-1:0] w_r;
    logic [DATA_W-1:0]        w_k;
    logic [DATA_W-1:0]        w_y_sat;
    logic [DATA_W-1:0]        w_y_out;
    logic                     w_unused_bits;

    // Negate in double width so the most negative input does not overflow
    assign w_neg_x      = -sext(r_x);
    assign w_k_prod     = w_neg_x * sext(c_inv_ln2);
    assign w_k          = DATA_W'(w_k_prod >>> (2 * FRAC_IN));
    assign w_kln2_prod  = sext(r_k) * sext(c_ln2);
    assign w_r          = r_x + DATA_W'(w_kln2_prod);
    assign w_mul        = sext(r_term) * sext(r_operand);
    assign w_p_scaled   = DATA_W'(r_prod >>> FRAC_IN);
    assign w_scale_prod = sext(w_p_scaled) * sext(w_recip[r_i]);
    assign w_term_next  = DATA_W'(w_scale_prod >>> FRAC_IN);

    always_comb begin
        w_y_sat = '0;
        if (r_acc[DATA_W-1]) begin
            w_y_sat = '0;
        end else if (r_acc >= c_one) begin
            w_y_sat = c_sat;
        end else begin
            w_y_sat = DATA_W'(r_acc) << c_out_shift;
        end
        w_y_out = w_y_sat;
        if (r_mode == 3'd1) begin
            w_y_out = (r_k >= c_k_max) ? '0 : (w_y_sat >> r_k);
        end
    end

    assign w_unused_bits = ^{bus.cmd_payload_inputs_1, bus.cmd_payload_function_id[9:3]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_y          <= '0;
            r_mode       <= '0;
            r_x          <= '0;
            r_operand    <= '0;
            r_term       <= '0;
            r_acc        <= '0;
            r_k          <= '0;
            r_prod       <= '0;
            r_i          <= '0;
            r_bypass     <= 1'b0;
            r_bypass_sat <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_x          <= bus.cmd_payload_inputs_0;
                        r_mode       <= bus.cmd_payload_function_id[2:0];
                        r_cmd_ready  <= 1'b0;
                        r_bypass     <= 1'b0;
                        r_bypass_sat <= 1'b0;
                        case (bus.cmd_payload_function_id[2:0])
                            3'd0:    r_state <= S_INIT;
                            3'd1:    r_state <= S_RED_K;
                            default: begin
                                r_bypass <= 1'b1;
                                r_state  <= S_DONE;
                            end
                        endcase
                    end
                end
                S_RED_K: begin
                    // exp of a non-negative input is >= 1.0 and always saturates
                    if (!r_x[DATA_W-1]) begin
                        r_bypass     <= 1'b1;
                        r_bypass_sat <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_k     <= w_k;
                        r_state <= S_RED_R;
                    end
                end
                S_RED_R: begin
                    r_operand <= w_r;
                    r_state   <= S_INIT;
                end
                S_INIT: begin
                    r_acc  <= c_one;
                    r_term <= c_one;
                    r_i    <= c_i_w'(1);
                    if (r_mode == 3'd0) begin
                        r_operand <= r_x;
                    end
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    r_prod  <= w_mul;
                    r_state <= S_SCALE;
                end
                S_SCALE: begin
                    r_term  <= w_term_next;
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    r_acc <= r_acc + r_term;
                    if (r_i == c_i_w'(N_TERMS)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_i     <= r_i + 1'b1;
                        r_state <= S_MUL;
                    end
                end
                S_DONE: begin
                    r_y         <= r_bypass ? (r_bypass_sat ? c_sat : '0) : w_y_out;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready             = r_cmd_ready;
    assign bus.rsp_valid             = r_rsp_valid;
    assign bus.rsp_payload_outputs_0 = r_y;

endmodule
`default_nettype wire
